// File: rtl/pe_router_pkg.sv
// Shared types and config-vector slicing helpers for the CGRA routing node.
// Config layout, LSB first: masks, then output selects, then input-mode enables.
package pe_router_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } router_state_e;

    function automatic int mask_off(input int i, input int maskW);
        return i * maskW;
    endfunction

    function automatic int sel_off(input int j, input int numPorts, input int maskW, input int selW);
        return numPorts * maskW + j * selW;
    endfunction

    function automatic int en_off(input int i, input int numPorts, input int maskW, input int selW);
        return numPorts * (maskW + selW) + i;
    endfunction

    // Position k among the ports other than i, in ascending order.
    function automatic int other_idx(input int i, input int k);
        return (k < i) ? k : k + 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pe_router_node_fifo.sv
// Per-input elastic buffer: a circular FIFO when enabled, otherwise a zero-latency bypass.
module pe_elastic_fifo
    import pe_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_allow,
    input  logic [DATA_WIDTH-1:0] i_pushData,
    input  logic                  i_pushValid,
    input  logic                  i_forkOk,
    input  logic                  i_pop,
    output logic                  o_pushReady,
    output logic [DATA_WIDTH-1:0] o_headData,
    output logic                  o_headNonEmpty,
    output logic [CNT_W-1:0]      o_count
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    // Ready ignores a same-cycle pop, so DEPTH=1 alternates fill and drain.
    assign o_pushReady    = i_enable ? (i_allow && (r_count < CNT_W'(DEPTH)))
                                     : (i_allow && i_forkOk);
    assign o_headData     = i_enable ? r_mem[r_rdPtr] : i_pushData;
    assign o_headNonEmpty = i_enable ? (r_count != '0) : (i_pushValid && i_allow);
    assign o_count        = r_count;

    assign w_push = i_enable && i_pushValid && o_pushReady;
    assign w_pop  = i_enable && i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pe_router_node.sv
// N-port CGRA routing node: per-input elastic buffers, forks to masked consumers,
// per-output muxes, and a drain-then-load reconfiguration sequencer.
module pe_router_node
    import pe_router_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_PORTS   = 4,
    parameter int NUM_CELL_IN = 3,
    parameter int FIFO_DEPTH  = 2,
    localparam int MASK_W     = NUM_PORTS - 1 + NUM_CELL_IN,
    localparam int SEL_W      = $clog2(NUM_PORTS),
    localparam int CFG_W      = NUM_PORTS * MASK_W + NUM_PORTS * SEL_W + NUM_PORTS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
    input  logic [NUM_PORTS-1:0]            din_v,
    output logic [NUM_PORTS-1:0]            din_r,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_PORTS-1:0]            dout_v,
    input  logic [NUM_PORTS-1:0]            dout_r,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] cell_din,
    output logic [NUM_PORTS-1:0]            cell_din_v,
    input  logic [NUM_CELL_IN-1:0]          cell_in_r,
    input  logic [DATA_WIDTH-1:0]           cell_dout,
    input  logic                            cell_dout_v,
    output logic                            cell_dout_r,
    input  logic [CFG_W-1:0]                config_bits,
    input  logic                            catch_config,
    output logic                            cfg_busy,
    output logic                            cfg_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    router_state_e         r_state;
    logic [CFG_W-1:0]      r_cfg;
    logic [CFG_W-1:0]      r_shadow;
    logic                  r_cfgLoaded;
    logic                  r_cfgDone;

    logic [NUM_PORTS-1:0]  w_enable;
    logic [MASK_W-1:0]     w_mask    [NUM_PORTS];
    logic [SEL_W-1:0]      w_sel     [NUM_PORTS];
    logic [MASK_W-1:0]     w_consRdy [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_forkOk;
    logic [NUM_PORTS-1:0]  w_headNonEmpty;
    logic [NUM_PORTS-1:0]  w_headValid;
    logic [DATA_WIDTH-1:0] w_headData [NUM_PORTS];
    logic [CNT_W-1:0]      w_count    [NUM_PORTS];
    logic                  w_allow;
    logic                  w_allEmpty;
    logic                  w_anyPush;
    logic                  w_cellDoutR;

    always_comb begin
        w_enable = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_enable[i] = r_cfg[en_off(i, NUM_PORTS, MASK_W, SEL_W)];
            w_mask[i]   = r_cfg[mask_off(i, MASK_W) +: MASK_W];
            w_sel[i]    = r_cfg[sel_off(i, NUM_PORTS, MASK_W, SEL_W) +: SEL_W];
        end
    end

    // New words are only accepted in RUN with a valid config; DRAIN keeps popping.
    assign w_allow = r_cfgLoaded && (r_state == RUN);

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_consRdy[i] = '0;
            for (int k = 0; k < NUM_PORTS - 1; k++) begin
                w_consRdy[i][k] = dout_r[other_idx(i, k)];
            end
            for (int c = 0; c < NUM_CELL_IN; c++) begin
                w_consRdy[i][NUM_PORTS-1+c] = cell_in_r[c];
            end
        end
    end

    always_comb begin
        w_forkOk    = '0;
        w_headValid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_forkOk[i]    = &(w_consRdy[i] | ~w_mask[i]);
            w_headValid[i] = r_cfgLoaded && w_headNonEmpty[i] && w_forkOk[i];
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
        pe_elastic_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_enable       (w_enable[gi]),
            .i_allow        (w_allow),
            .i_pushData     (din[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_pushValid    (din_v[gi]),
            .i_forkOk       (w_forkOk[gi]),
            .i_pop          (w_headValid[gi]),
            .o_pushReady    (din_r[gi]),
            .o_headData     (w_headData[gi]),
            .o_headNonEmpty (w_headNonEmpty[gi]),
            .o_count        (w_count[gi])
        );
    end

    always_comb begin
        w_cellDoutR = r_cfgLoaded;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (w_sel[j] == SEL_W'(NUM_PORTS - 1)) begin
                w_cellDoutR = w_cellDoutR & dout_r[j];
            end
        end
    end

    assign cell_dout_r = w_cellDoutR;

    always_comb begin
        dout       = '0;
        dout_v     = '0;
        cell_din   = '0;
        cell_din_v = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int k = 0; k < NUM_PORTS - 1; k++) begin
                if (w_sel[j] == SEL_W'(k)) begin
                    dout[j*DATA_WIDTH +: DATA_WIDTH] = w_headData[other_idx(j, k)];
                    dout_v[j]                        = w_headValid[other_idx(j, k)];
                end
            end
            if (w_sel[j] == SEL_W'(NUM_PORTS - 1)) begin
                dout[j*DATA_WIDTH +: DATA_WIDTH] = cell_dout;
                dout_v[j]                        = cell_dout_v && w_cellDoutR;
            end
            cell_din[j*DATA_WIDTH +: DATA_WIDTH] = w_headData[j];
            cell_din_v[j]                        = w_headValid[j];
        end
    end

    always_comb begin
        w_allEmpty = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_count[i] != '0) begin
                w_allEmpty = 1'b0;
            end
        end
    end

    // A word accepted in the catch cycle lands next cycle, so it must force DRAIN.
    assign w_anyPush = |(din_v & din_r & w_enable);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_cfg       <= '0;
            r_shadow    <= '0;
            r_cfgLoaded <= 1'b0;
            r_cfgDone   <= 1'b0;
        end else begin
            r_cfgDone <= 1'b0;
            case (r_state)
                RUN: begin
                    if (catch_config) begin
                        r_shadow <= config_bits;
                        r_state  <= (w_allEmpty && !w_anyPush) ? LOAD : DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_allEmpty) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_cfg       <= r_shadow;
                    r_cfgLoaded <= 1'b1;
                    r_cfgDone   <= 1'b1;
                    r_state     <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign cfg_busy = (r_state != RUN);
    assign cfg_done = r_cfgDone;

endmodule
